// File: rtl/matrix_result_slave_pkg.sv
// Shared constants and state encoding for the matrix result-RAM bus responder.
package matrix_result_slave_pkg;

  // The master's first result address is this same base
  localparam int unsigned ResultBaseAddr = 96;
  localparam int unsigned ResultDepth    = 16;
  localparam int unsigned BusAw          = 8;
  localparam int unsigned BusDw          = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StFull = 2'd2
  } slave_state_e;

endpackage

// File: rtl/matrix_result_slave_result_ram.sv
// Result storage: synchronous write, registered read, no reset on the array.
module matrix_result_slave_result_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Dw    = 32,
  localparam int unsigned Iw   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Iw-1:0] waddr_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic          re_i,
  input  logic [Iw-1:0] raddr_i,
  output logic [Dw-1:0] rdata_o
);

  logic [Dw-1:0] mem_q [Depth];
  logic [Dw-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_result_slave.sv
// Bus responder for the result window: stores results, counts them, flags completion.
// Define RESULT_STATUS_EN to expose a read-only status word at BASE_ADDR+DEPTH.
module matrix_result_slave
  import matrix_result_slave_pkg::*;
#(
  parameter int unsigned BASE_ADDR = ResultBaseAddr,
  parameter int unsigned DEPTH     = ResultDepth,
  parameter int unsigned AW        = BusAw,
  parameter int unsigned DW        = BusDw
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          S_sel,
  input  logic          S_wr,
  input  logic [AW-1:0] S_address,
  input  logic [DW-1:0] S_din,
  output logic [DW-1:0] S_dout,
  output logic          s_interrupt,
  output logic          s_full,
  output logic          s_ovf
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam logic [AW:0] BaseLo = (AW+1)'(BASE_ADDR);
  localparam logic [AW:0] BaseHi = (AW+1)'(BASE_ADDR + DEPTH);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  slave_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic          ram_sel_q, ram_sel_d;

  logic [AW:0]   addr_ext;
  logic          hit;
  logic          wr_hit;
  logic          rd_hit;
  logic          wr_accept;
  logic [IW-1:0] index;
  logic [DW-1:0] ram_rdata;

  // One extra bit so the upper window bound cannot wrap
  assign addr_ext  = {1'b0, S_address};
  assign hit       = S_sel && (addr_ext >= BaseLo) && (addr_ext < BaseHi);
  assign wr_hit    = hit && S_wr;
  assign rd_hit    = hit && !S_wr;
  assign index     = IW'(S_address - AW'(BASE_ADDR));
  assign wr_accept = wr_hit && !clear && (state_q != StFull);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    irq_d     = 1'b0;
    ovf_d     = ovf_q;
    ram_sel_d = rd_hit;
    if (clear) begin
      state_d   = StIdle;
      count_d   = '0;
      ovf_d     = 1'b0;
      ram_sel_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StFill: begin
          if (wr_hit) begin
            count_d = count_q + CW'(1);
            if (count_d == CountFull) begin
              state_d = StFull;
              irq_d   = 1'b1;
            end else begin
              state_d = StFill;
            end
          end
        end
        StFull: begin
          if (wr_hit) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ram_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
      ovf_q     <= ovf_d;
      ram_sel_q <= ram_sel_d;
    end
  end

  matrix_result_slave_result_ram #(
    .Depth (DEPTH),
    .Dw    (DW)
  ) u_result_ram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (index),
    .wdata_i (S_din),
    .re_i    (rd_hit),
    .raddr_i (index),
    .rdata_o (ram_rdata)
  );

  assign s_interrupt = irq_q;
  assign s_full      = (state_q == StFull);
  assign s_ovf       = ovf_q;

`ifdef RESULT_STATUS_EN
  logic          stat_hit;
  logic [DW-1:0] stat_q, stat_d;

  assign stat_hit = S_sel && !S_wr && (addr_ext == BaseHi);

  always_comb begin
    stat_d = '0;
    if (stat_hit && !clear) begin
      stat_d = DW'({ovf_q, s_full, count_q});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign S_dout = ram_sel_q ? ram_rdata : stat_q;
`else
  assign S_dout = ram_sel_q ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_matrix_result_slave.sv
// Directed bench for matrix_result_slave with a per-cycle behavioural model.
module tb_matrix_result_slave;

  localparam int Base  = 96;
  localparam int Depth = 16;
`ifdef RESULT_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        clear     = 1'b0;
  logic        S_sel     = 1'b0;
  logic        S_wr      = 1'b0;
  logic [7:0]  S_address = '0;
  logic [31:0] S_din     = '0;
  logic [31:0] S_dout;
  logic        s_interrupt;
  logic        s_full;
  logic        s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_result_slave dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_address   (S_address),
    .S_din       (S_din),
    .S_dout      (S_dout),
    .s_interrupt (s_interrupt),
    .s_full      (s_full),
    .s_ovf       (s_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results stored, writes counted, completion when count reaches Depth
  logic [31:0] m_mem   [Depth];
  bit          m_valid [Depth];
  int          m_cnt        = 0;
  bit          m_ovf        = 1'b0;
  bit          m_irq        = 1'b0;
  logic [31:0] m_dout       = '0;
  bit          m_dout_known = 1'b1;
  int          m_a;
  bit          m_win;

  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_irq = 1'b0;
      m_dout = '0;
      m_dout_known = 1'b1;
    end else begin
      m_a   = int'(S_address);
      m_win = S_sel && (m_a >= Base) && (m_a < Base + Depth);
      m_irq = 1'b0;
      m_dout = '0;
      m_dout_known = 1'b1;
      if (clear) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end else if (m_win && S_wr) begin
        if (m_cnt == Depth) begin
          m_ovf = 1'b1;
        end else begin
          m_mem[m_a - Base]   = S_din;
          m_valid[m_a - Base] = 1'b1;
          m_cnt++;
          m_irq = (m_cnt == Depth);
        end
      end else if (m_win) begin
        m_dout       = m_mem[m_a - Base];
        m_dout_known = m_valid[m_a - Base];
      end else if (StatusEn && S_sel && !S_wr && (m_a == Base + Depth)) begin
        m_dout = {25'd0, m_ovf, (m_cnt == Depth), 5'(m_cnt)};
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    check("s_interrupt", {31'd0, s_interrupt}, {31'd0, m_irq});
    check("s_full", {31'd0, s_full}, {31'd0, (m_cnt == Depth)});
    check("s_ovf", {31'd0, s_ovf}, {31'd0, m_ovf});
    if (m_dout_known) check("S_dout", S_dout, m_dout);
  end

  task automatic cyc(input bit sel, input bit wr, input int addr, input int data, input bit clr);
    @(negedge clk);
    S_sel     = sel;
    S_wr      = wr;
    S_address = 8'(addr);
    S_din     = 32'(data);
    clear     = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int addr, input int data);
    cyc(1'b1, 1'b1, addr, data, 1'b0);
  endtask

  task automatic rd(input int addr);
    cyc(1'b1, 1'b0, addr, 0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    idle();
    idle();
    check("reset S_dout", S_dout, 32'h0);
    check("reset s_full", {31'd0, s_full}, 32'h0);
    check("reset s_ovf", {31'd0, s_ovf}, 32'h0);
    reset_n = 1'b1;

    // First fill
    for (int i = 0; i < Depth; i++) begin
      wr(Base + i, 32'h100 + i);
      if (i == Depth - 2) check("irq before last write", {31'd0, s_interrupt}, 32'h0);
    end
    check("irq after 16th write", {31'd0, s_interrupt}, 32'h1);
    check("full after fill", {31'd0, s_full}, 32'h1);
    check("no ovf after fill", {31'd0, s_ovf}, 32'h0);
    idle();
    check("irq is one cycle", {31'd0, s_interrupt}, 32'h0);

    rd(100);
    check("read 100", S_dout, 32'h104);
    idle();
    check("dout idle after read", S_dout, 32'h0);
    rd(95);
    check("read 95", S_dout, 32'h0);
    rd(112);
    check("read 112", S_dout, StatusEn ? 32'h30 : 32'h0);

    // Overflow while full
    wr(96, 32'hDEAD);
    check("ovf set", {31'd0, s_ovf}, 32'h1);
    check("no second irq", {31'd0, s_interrupt}, 32'h0);
    rd(96);
    check("read 96 after ovf", S_dout, 32'h100);
`ifdef RESULT_STATUS_EN
    rd(112);
    check("status full+ovf", S_dout, 32'h70);
`endif

    // Clear with a coincident write
    cyc(1'b1, 1'b1, 97, 32'hBEEF, 1'b1);
    check("clear s_ovf", {31'd0, s_ovf}, 32'h0);
    check("clear s_full", {31'd0, s_full}, 32'h0);
    rd(97);
    check("97 retained", S_dout, 32'h101);
    for (int i = 0; i < Depth; i++) wr(Base + i, 32'h200 + i);
    check("irq on refill", {31'd0, s_interrupt}, 32'h1);

    // Partial fill then asynchronous reset mid-cycle
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) wr(Base + i, 32'h300 + i);
    rd(96);
    check("read 96 partial", S_dout, 32'h300);
    reset_n = 1'b0;
    #1;
    check("async reset S_dout", S_dout, 32'h0);
    check("async reset s_full", {31'd0, s_full}, 32'h0);
    idle();
    idle();
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) wr(Base + i, 32'h400 + i);
`ifdef RESULT_STATUS_EN
    rd(112);
    check("status count 5", S_dout, 32'h05);
`endif
    for (int i = 5; i < Depth; i++) begin
      wr(Base + i, 32'h400 + i);
      if (i == Depth - 2) check("no irq at 15 after reset", {31'd0, s_interrupt}, 32'h0);
    end
    check("irq after reset refill", {31'd0, s_interrupt}, 32'h1);
    rd(105);
    check("read 105", S_dout, 32'h409);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
